// File: rtl/bts_trunc_serial_pkg.sv
// bts_trunc_serial_pkg: shared FSM encoding and sizing helpers for the
// bit-serial truncated subtractor.
package bts_trunc_serial_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nslice(input int w, input int s);
      return (w + s - 1) / s;
   endfunction

   function automatic int idx_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bts_trunc_serial_slice.sv
// bts_trunc_serial_slice: combinational SLICE-bit subtract with borrow in/out.
module bts_trunc_serial_slice #(
   parameter int SLICE = 3
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic             borrow_in,
   output logic [SLICE-1:0] diff,
   output logic             borrow_out
);

   // One extra MSB captures the borrow as the sign of the widened difference.
   assign {borrow_out, diff} = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, borrow_in};

endmodule

// File: rtl/bts_trunc_serial.sv
// bts_trunc_serial: bit-serial subtractor of the upper BWOP-NAB operand bits,
// low NAB result bits forced to zero, valid/ready on both sides.
module bts_trunc_serial
   import bts_trunc_serial_pkg::*;
#(
   parameter int BWOP  = 10,
   parameter int NAB   = 1,
   parameter int SLICE = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BWOP-1:0] a,
   input  logic [BWOP-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BWOP-1:0] c,
   output logic            borrow,
   output logic            busy
);

   localparam int W  = BWOP - NAB;
   localparam int NS = nslice(W, SLICE);
   localparam int PW = NS * SLICE;
   localparam int IW = idx_w(NS);
   localparam logic [IW-1:0] LAST = IW'(NS - 1);

   state_t          state, nxt;
   logic [IW-1:0]   idx;
   logic [PW-1:0]   a_r, b_r, res;
   logic            bor;
   logic [SLICE-1:0] sa, sb, sd;
   logic            sbo;
   logic            accept;

   assign in_ready  = state == IDLE;
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_valid & in_ready;
   assign c         = BWOP'(res[W-1:0]) << NAB;
   assign borrow    = bor;

   // Operands are zero-padded to PW bits so the last partial slice borrows exactly.
   assign sa = a_r[int'(idx)*SLICE +: SLICE];
   assign sb = b_r[int'(idx)*SLICE +: SLICE];

   bts_trunc_serial_slice #(.SLICE(SLICE)) u_slice (
      .a          (sa),
      .b          (sb),
      .borrow_in  (bor),
      .diff       (sd),
      .borrow_out (sbo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (state == IDLE && in_valid)           nxt = RUN;
      else if (state == RUN && idx == LAST)    nxt = DONE;
      else if (state == DONE && out_ready)     nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
         a_r <= '0;
         b_r <= '0;
         res <= '0;
         bor <= 1'b0;
      end else if (accept) begin
         idx <= '0;
         a_r <= PW'(a[BWOP-1:NAB]);
         b_r <= PW'(b[BWOP-1:NAB]);
         res <= '0;
         bor <= 1'b0;
      end else if (state == RUN) begin
         res[int'(idx)*SLICE +: SLICE] <= sd;
         bor <= sbo;
         idx <= idx == LAST ? '0 : idx + 1'b1;
      end
   end

endmodule
